mul_div_exec_unit: RTL
======================

// Module: mul_div_exec_unit
// PURPOSE
//  Parametrised multiply/divide functional unit for the Tomasulo core.
//  Takes one op at a time from the mul/div reservation station over a valid/ready issue port.
//  Multiply: fixed MUL_LAT cycles. Divide: restoring, one quotient bit per cycle.
//  Result and tags are held on a CDB port until the CDB arbiter grants them, then the unit frees.
// PARAMETERS
//  W        8  operand width; product is 2W
//  ROB_W    3  ROB index width
//  RS_W     3  reservation-station index width
//  RD_W     4  destination register index width
//  MUL_LAT  3  multiply latency in cycles, >=1
// PORTS
//  clk1        in   1      clock, all state on posedge
//  rst_n       in   1      async active-low reset
//  flush       in   1      squash in-flight op (branch mispredict)
//  issue_valid in   1      RS presents an op
//  issue_ready out  1      unit can accept this cycle
//  issue_func  in   4      4'b0010 MUL, 4'b0011 DIV, others illegal
//  issue_a     in   W      rs1 operand, unsigned
//  issue_b     in   W      rs2 operand, unsigned
//  issue_rob   in   ROB_W  ROB tag
//  issue_rs    in   RS_W   RS entry index to release
//  issue_rd    in   RD_W   destination register
//  cdb_valid   out  1      result pending on CDB
//  cdb_ready   in   1      CDB grant; transfer when valid&ready
//  cdb_data    out  2W     MUL: product. DIV: {remainder, quotient}
//  cdb_err     out  1      divide-by-zero or illegal func
//  cdb_rob     out  ROB_W  captured tag
//  cdb_rs      out  RS_W   captured tag
//  cdb_rd      out  RD_W   captured tag
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; cdb_valid=0; cdb_err=0; cdb_data, tags, counter all 0; busy=0.
//    Async reset applies mid-operation and drops the op; no CDB write is made.
//  issue_ready = (state==IDLE) & ~flush.
//    Accept on the edge with issue_valid & issue_ready (edge 0).
//    Operands, func and tags are captured at edge 0 and stay stable until release.
//  FSM IDLE -> MUL | DIV | DONE(err) on accept.
//    MUL: cnt counts MUL_LAT-1..0. cdb_valid is 1 after edge MUL_LAT.
//    DIV: W iterations, one per edge, MSB first: rem=(rem<<1)|a[i]; if rem>=b, rem-=b and q[i]=1.
//      cdb_valid is 1 after edge W+1.
//    Div by zero: no iteration. After edge 1: cdb_valid=1, err=1, quotient all-ones, remainder=a.
//    Illegal func: after edge 1: cdb_valid=1, err=1, data=0.
//    DONE: outputs hold while cdb_ready=0 (any number of cycles).
//      valid&ready at an edge -> IDLE, cdb_valid=0.
//      The next op is not accepted in that same cycle (issue_ready=0 in DONE).
//  flush: highest priority. At the next edge state->IDLE and cdb_valid=0, from any state.
//    A DONE result is dropped even if cdb_ready=1 in the same cycle.
//  Width: mul is a full 2W product, no truncation. Quotient and remainder are W bits each.
// TESTING
//  T1 MUL: a=3, b=5 -> cdb_valid after 3 edges, data=16'd15, err=0, tags echoed.
//  T2 DIV: a=200, b=7 -> valid after 9 edges, data={8'd4, 8'd28}.
//     Also a=7, b=200 -> {7, 0}.
//  T3 DIV: b=0, a=9 -> valid after 1 edge, err=1, data={8'd9, 8'hFF}.
//     Illegal func 4'b0101 -> err=1, data=0.
//  T4 Backpressure: MUL 255*255 with cdb_ready=0 for 5 cycles.
//     -> data=16'hFE01 held stable, issue_ready=0; freed on the cycle after grant.
//  T5 Flush at DIV iteration 4 -> IDLE next edge, no cdb_valid.
//     New MUL 2*2 accepted next cycle -> 4.
//  T6 rst_n low mid-MUL -> all outputs 0 immediately.
//     After release, the first op completes correctly.

Source files
------------

// File: rtl/mul_div_exec_unit.sv
// Multiply/divide functional unit: one op in flight, fixed-latency multiply,
// restoring divide, result held on the CDB port until granted.
module mul_div_exec_unit #(
  parameter int W       = 8,
  parameter int ROB_W   = 3,
  parameter int RS_W    = 3,
  parameter int RD_W    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_func,
  input  logic [W-1:0]     issue_a,
  input  logic [W-1:0]     issue_b,
  input  logic [ROB_W-1:0] issue_rob,
  input  logic [RS_W-1:0]  issue_rs,
  input  logic [RD_W-1:0]  issue_rd,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [2*W-1:0]   cdb_data,
  output logic             cdb_err,
  output logic [ROB_W-1:0] cdb_rob,
  output logic [RS_W-1:0]  cdb_rs,
  output logic [RD_W-1:0]  cdb_rd,
  output logic             busy
);
  localparam logic [3:0] FN_MUL = 4'b0010;
  localparam logic [3:0] FN_DIV = 4'b0011;
  localparam int MAXC  = (W > MUL_LAT) ? W : MUL_LAT;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_n;

  logic [W-1:0]     op_a, op_b, div_a, rem, quo;
  logic [3:0]       op_func;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   prod;
  logic [W:0]       rem_sh;
  logic             rem_ge;
  logic             accept;

  assign issue_ready = (state == S_IDLE) & ~flush;
  assign accept      = issue_valid & issue_ready;
  assign busy        = (state != S_IDLE);
  assign prod        = (2*W)'(op_a) * (2*W)'(op_b);
  // Restoring step: shift next dividend bit (MSB first) into the partial remainder.
  assign rem_sh      = {rem, div_a[W-1]};
  assign rem_ge      = (rem_sh >= {1'b0, op_b});

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) begin
        if (issue_func == FN_MUL)                          state_n = S_MUL;
        else if (issue_func == FN_DIV && issue_b != '0)    state_n = S_DIV;
        else                                               state_n = S_DONE;
      end
      S_MUL:  if (cnt == '0) state_n = S_DONE;
      S_DIV:  if (cnt == '0) state_n = S_DONE;
      S_DONE: if (cdb_valid && cdb_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0; op_b <= '0; op_func <= '0; div_a <= '0; rem <= '0; quo <= '0;
      cnt <= '0; cdb_valid <= 1'b0; cdb_err <= 1'b0; cdb_data <= '0;
      cdb_rob <= '0; cdb_rs <= '0; cdb_rd <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      cdb_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_a <= issue_a; op_b <= issue_b; op_func <= issue_func; div_a <= issue_a;
          rem <= '0; quo <= '0;
          cdb_rob <= issue_rob; cdb_rs <= issue_rs; cdb_rd <= issue_rd;
          cnt <= (issue_func == FN_MUL) ? CNT_MUL : CNT_DIV;
        end
        S_MUL: begin
          if (cnt == '0) begin
            cdb_valid <= 1'b1; cdb_err <= 1'b0; cdb_data <= prod;
          end else cnt <= cnt - 1'b1;
        end
        S_DIV: begin
          if (cnt == '0) begin
            cdb_valid <= 1'b1; cdb_err <= 1'b0; cdb_data <= {rem, quo};
          end else begin
            rem   <= rem_ge ? W'(rem_sh - {1'b0, op_b}) : rem_sh[W-1:0];
            quo   <= {quo[W-2:0], rem_ge};
            div_a <= div_a << 1;
            cnt   <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          // Entered with cdb_valid low only on the error paths; publish one edge later.
          if (!cdb_valid) begin
            cdb_valid <= 1'b1;
            cdb_err   <= 1'b1;
            cdb_data  <= (op_func == FN_DIV) ? {op_a, {W{1'b1}}} : '0;
          end else if (cdb_ready) begin
            cdb_valid <= 1'b0;
            cdb_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
